// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/compare ops plus an iterative shift-add multiplier
// and restoring divider behind a start/busy/done handshake. Every result is registered.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CW    = 6,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    controlALU,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] outALU,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [1:0]       dbg_state
);

  // Handshake: an op is accepted on any rising edge with start=1 while busy=0; operands are
  // captured on that edge. done is a one-cycle pulse marking outALU valid; start during
  // busy=1 is dropped, so the requester holds start until it sees busy=0.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW-1:0] OP_ADD  = CW'(1);
  localparam logic [CW-1:0] OP_ADDI = CW'(2);
  localparam logic [CW-1:0] OP_SUB  = CW'(3);
  localparam logic [CW-1:0] OP_SUBI = CW'(4);
  localparam logic [CW-1:0] OP_MUL  = CW'(5);
  localparam logic [CW-1:0] OP_DIV  = CW'(6);
  localparam logic [CW-1:0] OP_MOD  = CW'(7);
  localparam logic [CW-1:0] OP_AND  = CW'(8);
  localparam logic [CW-1:0] OP_ANDI = CW'(9);
  localparam logic [CW-1:0] OP_OR   = CW'(10);
  localparam logic [CW-1:0] OP_ORI  = CW'(11);
  localparam logic [CW-1:0] OP_XOR  = CW'(12);
  localparam logic [CW-1:0] OP_XORI = CW'(13);
  localparam logic [CW-1:0] OP_NOT  = CW'(14);
  localparam logic [CW-1:0] OP_SHL  = CW'(15);
  localparam logic [CW-1:0] OP_SHR  = CW'(16);
  localparam logic [CW-1:0] OP_BEQ  = CW'(21);
  localparam logic [CW-1:0] OP_BGT  = CW'(22);
  localparam logic [CW-1:0] OP_BGE  = CW'(23);
  localparam logic [CW-1:0] OP_BLT  = CW'(24);
  localparam logic [CW-1:0] OP_BLE  = CW'(25);
  localparam logic [CW-1:0] OP_BNE  = CW'(26);
  localparam logic [CW-1:0] OP_MOVE = CW'(27);

  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;   // multiplicand / divisor
  logic [WIDTH-1:0] opb;   // multiplier / quotient (dividend shifts out of it)
  logic [WIDTH-1:0] acc;   // product / remainder

  logic             is_divop;
  logic             rt_zero;
  logic             go_iter;
  logic [WIDTH-1:0] simple_res;

  logic             in_idle;
  logic             step_mul;
  logic [WIDTH-1:0] s_a, s_b, s_acc;
  logic [WIDTH-1:0] n_a, n_b, n_acc;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_diff;

  assign dbg_state = state;
  assign is_divop  = (controlALU == OP_DIV) || (controlALU == OP_MOD);
  assign rt_zero   = (rt == '0);
  assign go_iter   = (controlALU == OP_MUL) || (is_divop && !rt_zero);

  always_comb begin
    simple_res = '0;
    case (controlALU)
      OP_ADD, OP_ADDI: simple_res = rs + rt;
      OP_SUB, OP_SUBI: simple_res = rs - rt;
      OP_AND, OP_ANDI: simple_res = rs & rt;
      OP_OR,  OP_ORI:  simple_res = rs | rt;
      OP_XOR, OP_XORI: simple_res = rs ^ rt;
      OP_NOT:          simple_res = ~rs;
      OP_SHL:          simple_res = (rt >= W_LIMIT) ? '0 : (rs << rt);
      OP_SHR:          simple_res = (rt >= W_LIMIT) ? '0 : (rs >> rt);
      OP_BEQ:          simple_res = {{(WIDTH-1){1'b0}}, rs == rt};
      OP_BGT:          simple_res = {{(WIDTH-1){1'b0}}, rs >  rt};
      OP_BGE:          simple_res = {{(WIDTH-1){1'b0}}, rs >= rt};
      OP_BLT:          simple_res = {{(WIDTH-1){1'b0}}, rs <  rt};
      OP_BLE:          simple_res = {{(WIDTH-1){1'b0}}, rs <= rt};
      OP_BNE:          simple_res = {{(WIDTH-1){1'b0}}, rs != rt};
      OP_MOVE:         simple_res = rs;
      default:         simple_res = '0;
    endcase
  end

  // One multiply/divide iteration. The first iteration runs on the accepting edge straight
  // from the operand inputs, which keeps MUL/DIV/MOD at WIDTH+1 cycles including FIN.
  always_comb begin
    in_idle  = (state == S_IDLE);
    step_mul = in_idle ? (controlALU == OP_MUL) : (op == OP_MUL);
    s_a      = opa;
    s_b      = opb;
    s_acc    = acc;
    if (in_idle) begin
      s_a   = step_mul ? rs : rt;
      s_b   = step_mul ? rt : rs;
      s_acc = '0;
    end
    r_sh   = {s_acc, s_b[WIDTH-1]};
    r_diff = r_sh - {1'b0, s_a};
    n_a    = s_a;
    n_b    = s_b;
    n_acc  = s_acc;
    if (step_mul) begin
      n_acc = s_acc + (s_b[0] ? s_a : '0);
      n_a   = s_a << 1;
      n_b   = s_b >> 1;
    end else if (r_sh >= {1'b0, s_a}) begin
      n_acc = r_diff[WIDTH-1:0];
      n_b   = {s_b[WIDTH-2:0], 1'b1};
    end else begin
      n_acc = r_sh[WIDTH-1:0];
      n_b   = {s_b[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op      <= '0;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      outALU  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op      <= controlALU;
            divZero <= 1'b0;
            if (go_iter) begin
              opa   <= n_a;
              opb   <= n_b;
              acc   <= n_acc;
              cnt   <= CNT_W'(WIDTH - 1);
              busy  <= 1'b1;
              state <= S_ITER;
            end else if (is_divop) begin
              outALU  <= (controlALU == OP_DIV) ? '1 : rs;
              divZero <= 1'b1;
              done    <= 1'b1;
            end else begin
              outALU <= simple_res;
              done   <= 1'b1;
            end
          end
        end
        S_ITER: begin
          opa <= n_a;
          opb <= n_b;
          acc <= n_acc;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIN;
        end
        S_FIN: begin
          outALU <= (op == OP_DIV) ? opb : acc;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
